// File: rtl/wb_fb_reader.sv
// wb_fb_reader: Wishbone framebuffer reader fetching 8-word bursts into a FIFO.
// Ports:
//   clk, rst (async, active-high)        clock and reset
//   enable, fifo_afull                   burst start gating
//   wb_cyc/stb/we/sel/adr/dat_ms         Wishbone master request (read-only)
//   wb_dat_sm, wb_ack, wb_err            Wishbone slave response
//   fifo_wr, fifo_wdata, fifo_sof        FIFO push (data passed straight from slave)
//   busy                                 high whenever not IDLE
module wb_fb_reader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          FRAME_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_ms,
  input  logic [31:0] wb_dat_sm,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic        fifo_afull,
  output logic        fifo_wr,
  output logic [31:0] fifo_wdata,
  output logic        fifo_sof,
  output logic        busy
);
  localparam int WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
  state_t        state_q, state_d;
  logic [WW-1:0] word_cnt_q, word_cnt_d;
  logic [2:0]    burst_cnt_q, burst_cnt_d;
  logic          take;
  // an error outranks a simultaneous ack: nothing is pushed and counters hold
  assign take = (state_q == BURST) && wb_ack && !wb_err;
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    burst_cnt_d = burst_cnt_q;
    state_d     = (state_q == IDLE)  ? ((enable && !fifo_afull) ? BURST : IDLE) :
                  (state_q == GAP)   ? IDLE :
                  (wb_err || (take && burst_cnt_q == 3'd7)) ? GAP : BURST;
    word_cnt_d  = take ? ((word_cnt_q == WW'(FRAME_WORDS - 1)) ? '0 : word_cnt_q + 1'b1) : word_cnt_q;
    burst_cnt_d = take ? burst_cnt_q + 3'd1 : burst_cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
  assign wb_cyc     = (state_q == BURST);
  assign wb_stb     = (state_q == BURST);
  assign wb_we      = 1'b0;
  assign wb_sel     = 4'hF;
  assign wb_dat_ms  = '0;
  assign wb_adr     = BASE_ADDR + (32'(word_cnt_q) << 2);
  assign fifo_wr    = take;
  assign fifo_wdata = wb_dat_sm;
  assign fifo_sof   = take && (word_cnt_q == '0);
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_wb_fb_reader.sv
// tb_wb_fb_reader: directed self-checking bench for wb_fb_reader.
module tb_wb_fb_reader;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          FW   = 16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_ms;
  logic [31:0] wb_dat_sm = '0;
  logic        wb_ack = 1'b0;
  logic        wb_err = 1'b0;
  logic        fifo_afull = 1'b0;
  logic        fifo_wr, fifo_sof, busy;
  logic [31:0] fifo_wdata;
  int total = 0;
  int bad = 0;
  wb_fb_reader #(.BASE_ADDR(BASE), .FRAME_WORDS(FW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_adr(wb_adr), .wb_dat_ms(wb_dat_ms), .wb_dat_sm(wb_dat_sm),
    .wb_ack(wb_ack), .wb_err(wb_err), .fifo_afull(fifo_afull),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .fifo_sof(fifo_sof), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] dv(input int w);
    return 32'hC0DE_0000 + 32'(w * 273);
  endfunction
  function automatic logic [31:0] ad(input int w);
    return BASE + 32'(4 * w);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic ack, input logic err, input logic [31:0] dat);
    @(negedge clk);
    wb_ack = ack;
    wb_err = err;
    wb_dat_sm = dat;
    #1;
  endtask
  task automatic push(input string tag, input int w);
    tick(1'b1, 1'b0, dv(w));
    chkb({tag, "_cyc"}, wb_cyc, 1'b1);
    chk({tag, "_adr"}, wb_adr, ad(w));
    chkb({tag, "_wr"}, fifo_wr, 1'b1);
    chk({tag, "_wdata"}, fifo_wdata, dv(w));
    chkb({tag, "_sof"}, fifo_sof, w == 0);
  endtask
  task automatic wait_ack(input string tag, input int w);
    tick(1'b0, 1'b0, '0);
    chkb({tag, "_stb"}, wb_stb, 1'b1);
    chk({tag, "_adr"}, wb_adr, ad(w));
    chkb({tag, "_wr"}, fifo_wr, 1'b0);
  endtask
  task automatic gap(input string tag, input logic ack);
    tick(ack, 1'b0, '0);
    chkb({tag, "_cyc"}, wb_cyc, 1'b0);
    chkb({tag, "_busy"}, busy, 1'b1);
    chkb({tag, "_wr"}, fifo_wr, 1'b0);
  endtask
  task automatic idle(input string tag, input logic ack);
    tick(ack, 1'b0, '0);
    chkb({tag, "_cyc"}, wb_cyc, 1'b0);
    chkb({tag, "_busy"}, busy, 1'b0);
    chkb({tag, "_wr"}, fifo_wr, 1'b0);
  endtask
  initial begin
    tick(1'b0, 1'b0, '0);
    chkb("rst_cyc", wb_cyc, 1'b0);
    chkb("rst_stb", wb_stb, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_wr", fifo_wr, 1'b0);
    chkb("rst_sof", fifo_sof, 1'b0);
    chk("rst_adr", wb_adr, BASE);
    chkb("const_we", wb_we, 1'b0);
    chk("const_sel", 32'(wb_sel), 32'hF);
    chk("const_dat", wb_dat_ms, 32'h0);
    rst = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 16; i++) wait_ack("lat_wait", 0);
    for (int i = 0; i < 8; i++) push("lat_push", i);
    gap("lat_gap", 1'b0);
    enable = 1'b0;
    idle("lat_idle0", 1'b0);
    idle("lat_idle1", 1'b0);
    fifo_afull = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 50; i++) idle("afull_hold", 1'b0);
    @(negedge clk);
    fifo_afull = 1'b0;
    #1;
    chkb("afull_fall_cyc", wb_cyc, 1'b0);
    push("drop_push", 8);
    push("drop_push", 9);
    push("drop_push", 10);
    fifo_afull = 1'b1;
    enable = 1'b0;
    for (int w = 11; w < 16; w++) push("drop_push", w);
    gap("drop_gap", 1'b0);
    for (int i = 0; i < 3; i++) idle("drop_idle", 1'b0);
    fifo_afull = 1'b0;
    enable = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) push("cont_push", (8 * b + i) % FW);
      gap("cont_gap", 1'b1);
      idle("cont_idle", 1'b1);
    end
    for (int w = 8; w < 13; w++) push("rst_push", w);
    wait_ack("rst_wait", 13);
    wait_ack("rst_wait", 13);
    @(negedge clk);
    rst = 1'b1;
    wb_ack = 1'b1;
    wb_dat_sm = dv(13);
    #1;
    chkb("mid_rst_cyc", wb_cyc, 1'b0);
    chkb("mid_rst_stb", wb_stb, 1'b0);
    chkb("mid_rst_busy", busy, 1'b0);
    chkb("mid_rst_wr", fifo_wr, 1'b0);
    chk("mid_rst_adr", wb_adr, BASE);
    idle("in_rst", 1'b1);
    rst = 1'b0;
    push("post_rst", 0);
    push("err_push", 1);
    push("err_push", 2);
    tick(1'b1, 1'b1, dv(3));
    chkb("err_cyc", wb_cyc, 1'b1);
    chk("err_adr", wb_adr, ad(3));
    chkb("err_wr", fifo_wr, 1'b0);
    gap("err_gap", 1'b0);
    idle("err_idle", 1'b0);
    for (int w = 3; w < 8; w++) push("resume_push", w);
    gap("resume_gap", 1'b0);
    enable = 1'b0;
    idle("end_idle", 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
